// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC / multdiv sequencer.
// Opcode and alu_op values, pc_sel encodings and the FSM state type.
package pc_seq_pkg;

  localparam logic [4:0] OP_ALU = 5'b00000;
  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_REL = 2'b01;
  localparam logic [1:0] SEL_ABS = 2'b10;
  localparam logic [1:0] SEL_REG = 2'b11;

  typedef enum logic [1:0] {
    S_RUN,
    S_ISSUE,
    S_MD_WAIT,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational decode of the decode-stage instruction:
// branch/jump taken resolution, PC source and mul/div detection.
module pc_seq_decode
  import pc_seq_pkg::*;
(
  input  logic       i_valid,
  input  logic [4:0] i_opcode,
  input  logic [4:0] i_alu_op,
  input  logic       i_ne,
  input  logic       i_lt,
  input  logic       i_nz,
  output logic       o_taken,
  output logic [1:0] o_sel,
  output logic       o_mul,
  output logic       o_div
);

  logic w_jmp;
  logic w_jr;
  logic w_bne;
  logic w_blt;
  logic w_bex;
  logic w_mul;
  logic w_div;

  assign w_jmp = (i_opcode == OP_J) || (i_opcode == OP_JAL);
  assign w_jr  = (i_opcode == OP_JR);
  assign w_bne = (i_opcode == OP_BNE);
  assign w_blt = (i_opcode == OP_BLT);
  assign w_bex = (i_opcode == OP_BEX);
  assign w_mul = (i_opcode == OP_ALU) && (i_alu_op == ALU_MUL);
  assign w_div = (i_opcode == OP_ALU) && (i_alu_op == ALU_DIV);

  // Opcodes are distinct, so at most one select is ever high.
  always_comb begin
    o_taken = 1'b0;
    o_sel   = SEL_SEQ;
    o_mul   = 1'b0;
    o_div   = 1'b0;
    if (i_valid) begin
      unique case (1'b1)
        w_jmp: begin
          o_taken = 1'b1;
          o_sel   = SEL_ABS;
        end
        w_jr: begin
          o_taken = 1'b1;
          o_sel   = SEL_REG;
        end
        w_bne: begin
          o_taken = i_ne;
          o_sel   = i_ne ? SEL_REL : SEL_SEQ;
        end
        w_blt: begin
          o_taken = i_lt;
          o_sel   = i_lt ? SEL_REL : SEL_SEQ;
        end
        w_bex: begin
          o_taken = i_nz;
          o_sel   = i_nz ? SEL_ABS : SEL_SEQ;
        end
        w_mul: o_mul = 1'b1;
        w_div: o_div = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC write/select sequencer with multdiv start and stall control.
// Define PC_SEQ_TIMEOUT_EN to abort an MD_WAIT lasting MD_TIMEOUT cycles.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inst_valid,
  input  logic [4:0] opcode,
  input  logic [4:0] alu_op,
  input  logic       alu_ne,
  input  logic       alu_lt,
  input  logic       rstatus_nz,
  input  logic       md_rdy,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       flush,
  output logic       ctrl_mult,
  output logic       ctrl_div,
  output logic       md_stall,
  output logic       md_timeout
);

  state_t     r_state;
  state_t     w_next;
  logic       r_op_div;
  logic       w_taken;
  logic [1:0] w_sel;
  logic       w_mul;
  logic       w_div;
  logic       w_to;

  pc_seq_decode u_dec (
    .i_valid  (inst_valid),
    .i_opcode (opcode),
    .i_alu_op (alu_op),
    .i_ne     (alu_ne),
    .i_lt     (alu_lt),
    .i_nz     (rstatus_nz),
    .o_taken  (w_taken),
    .o_sel    (w_sel),
    .o_mul    (w_mul),
    .o_div    (w_div)
  );

`ifdef PC_SEQ_TIMEOUT_EN
  logic [6:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset || r_state != S_MD_WAIT) r_cnt <= '0;
    else r_cnt <= r_cnt + 7'd1;
  end

  // A same-cycle md_rdy is a normal completion, not an abort.
  assign w_to = (r_state == S_MD_WAIT) && !md_rdy &&
                (r_cnt == 7'(MD_TIMEOUT - 1));
`else
  assign w_to = (MD_TIMEOUT < 0);
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_RUN;
      r_op_div <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RUN && (w_mul || w_div)) r_op_div <= w_div;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_mul || w_div) w_next = S_ISSUE;
        else if (w_taken) w_next = S_FLUSH;
      end
      S_ISSUE:   w_next = S_MD_WAIT;
      S_MD_WAIT: if (md_rdy || w_to) w_next = S_RUN;
      S_FLUSH:   w_next = S_RUN;
      default:   w_next = S_RUN;
    endcase
  end

  // Everything is held low while reset is asserted.
  always_comb begin
    pc_we      = 1'b0;
    pc_sel     = SEL_SEQ;
    flush      = 1'b0;
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    md_stall   = 1'b0;
    md_timeout = 1'b0;
    if (reset) begin
      unique case (r_state)
        S_RUN: begin
          pc_we  = !(w_mul || w_div);
          pc_sel = w_sel;
        end
        S_ISSUE: begin
          ctrl_mult = !r_op_div;
          ctrl_div  = r_op_div;
          md_stall  = 1'b1;
        end
        S_MD_WAIT: begin
          pc_we      = md_rdy || w_to;
          md_stall   = !(md_rdy || w_to);
          md_timeout = w_to;
        end
        S_FLUSH: begin
          flush = 1'b1;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: decode vector table,
// hand-built multdiv/reset/flush sequences and a random model run.
module tb_pc_seq_ctrl;

  localparam int TO = 4;
`ifdef PC_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       inst_valid = 1'b0;
  logic [4:0] opcode = '0;
  logic [4:0] alu_op = '0;
  logic       alu_ne = 1'b0;
  logic       alu_lt = 1'b0;
  logic       rstatus_nz = 1'b0;
  logic       md_rdy = 1'b0;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       flush;
  logic       ctrl_mult;
  logic       ctrl_div;
  logic       md_stall;
  logic       md_timeout;

  pc_seq_ctrl #(.MD_TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .inst_valid (inst_valid),
    .opcode     (opcode),
    .alu_op     (alu_op),
    .alu_ne     (alu_ne),
    .alu_lt     (alu_lt),
    .rstatus_nz (rstatus_nz),
    .md_rdy     (md_rdy),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .flush      (flush),
    .ctrl_mult  (ctrl_mult),
    .ctrl_div   (ctrl_div),
    .md_stall   (md_stall),
    .md_timeout (md_timeout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       v;
    logic [4:0] op;
    logic [4:0] alu;
    logic       ne;
    logic       lt;
    logic       nz;
    logic       we;
    logic [1:0] sel;
    logic       fl;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(string nm, logic [1:0] act, logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic ck7(string t, logic we, logic [1:0] sel, logic fl,
                     logic mu, logic dv, logic st, logic to);
    chk({t, ".pc_we"}, pc_we, we);
    chk({t, ".pc_sel"}, pc_sel, sel);
    chk({t, ".flush"}, flush, fl);
    chk({t, ".ctrl_mult"}, ctrl_mult, mu);
    chk({t, ".ctrl_div"}, ctrl_div, dv);
    chk({t, ".md_stall"}, md_stall, st);
    chk({t, ".md_timeout"}, md_timeout, to);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(logic v, logic [4:0] op, logic [4:0] alu,
                     logic ne, logic lt, logic nz, logic rdy);
    inst_valid = v;
    opcode     = op;
    alu_op     = alu;
    alu_ne     = ne;
    alu_lt     = lt;
    rstatus_nz = nz;
    md_rdy     = rdy;
  endtask

  task automatic idle(logic rdy);
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  // Behavioural model: what the sequencer owes the pipeline this cycle.
  bit m_bubble;
  int m_start;
  bit m_waiting;
  int m_waited;
  bit n_bubble;
  int n_start;
  bit n_waiting;
  int n_waited;
  logic e_we, e_fl, e_mu, e_dv, e_st, e_to;
  logic [1:0] e_sel;

  task automatic model_eval();
    logic tk;
    logic [1:0] s;
    {e_we, e_fl, e_mu, e_dv, e_st, e_to} = '0;
    e_sel = 2'b00;
    n_bubble = 0;
    n_start = 0;
    n_waiting = 0;
    n_waited = 0;
    if (!reset) begin
    end else if (m_bubble) begin
      e_fl = 1;
      e_we = 1;
    end else if (m_start != 0) begin
      e_mu = (m_start == 1);
      e_dv = (m_start == 2);
      e_st = 1;
      n_waiting = 1;
    end else if (m_waiting) begin
      if (md_rdy) e_we = 1;
      else if (TO_EN && m_waited + 1 >= TO) begin
        e_we = 1;
        e_to = 1;
      end else begin
        e_st = 1;
        n_waiting = 1;
        n_waited = m_waited + 1;
      end
    end else if (!inst_valid) begin
      e_we = 1;
    end else if (opcode == 0 && alu_op == 6) begin
      n_start = 1;
    end else if (opcode == 0 && alu_op == 7) begin
      n_start = 2;
    end else begin
      e_we = 1;
      tk = 0;
      s = 2'b00;
      case (opcode)
        5'd1, 5'd3: begin tk = 1; s = 2'b10; end
        5'd4:  begin tk = 1; s = 2'b11; end
        5'd2:  begin tk = alu_ne; s = 2'b01; end
        5'd6:  begin tk = alu_lt; s = 2'b01; end
        5'd22: begin tk = rstatus_nz; s = 2'b10; end
        default: ;
      endcase
      if (tk) begin
        e_sel = s;
        n_bubble = 1;
      end
    end
  endtask

  initial begin
    logic [4:0] ops[8];
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd22, 5'd5};

    vecs[0]  = '{1, 5'd2,  5'd0, 1, 0, 0, 1, 2'b01, 1};
    vecs[1]  = '{1, 5'd2,  5'd0, 0, 1, 1, 1, 2'b00, 0};
    vecs[2]  = '{1, 5'd4,  5'd0, 0, 0, 0, 1, 2'b11, 1};
    vecs[3]  = '{1, 5'd22, 5'd0, 1, 1, 0, 1, 2'b00, 0};
    vecs[4]  = '{1, 5'd22, 5'd0, 0, 0, 1, 1, 2'b10, 1};
    vecs[5]  = '{1, 5'd1,  5'd0, 0, 0, 0, 1, 2'b10, 1};
    vecs[6]  = '{1, 5'd3,  5'd0, 0, 0, 0, 1, 2'b10, 1};
    vecs[7]  = '{1, 5'd6,  5'd0, 0, 1, 0, 1, 2'b01, 1};
    vecs[8]  = '{1, 5'd6,  5'd0, 1, 0, 1, 1, 2'b00, 0};
    vecs[9]  = '{1, 5'd5,  5'd6, 1, 1, 1, 1, 2'b00, 0};
    vecs[10] = '{0, 5'd1,  5'd0, 0, 0, 0, 1, 2'b00, 0};
    vecs[11] = '{1, 5'd0,  5'd0, 1, 1, 1, 1, 2'b00, 0};
    vecs[12] = '{0, 5'd2,  5'd0, 1, 0, 0, 1, 2'b00, 0};

    // Reset: outputs forced low even with a jump presented.
    reset = 0;
    drv(1, 5'd1, 5'd0, 0, 0, 0, 1);
    #3;
    ck7("rst0", 0, 0, 0, 0, 0, 0, 0);
    tick();
    #3;
    ck7("rst1", 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1;
    idle(0);
    #3;
    ck7("rst_rel", 1, 0, 0, 0, 0, 0, 0);
    tick();

    // Decode table: the decode cycle, then the cycle after.
    for (int i = 0; i < 13; i++) begin
      drv(vecs[i].v, vecs[i].op, vecs[i].alu,
          vecs[i].ne, vecs[i].lt, vecs[i].nz, 0);
      #3;
      chk($sformatf("vec%0d.pc_we", i), pc_we, vecs[i].we);
      chk($sformatf("vec%0d.pc_sel", i), pc_sel, vecs[i].sel);
      chk($sformatf("vec%0d.stall", i), md_stall, 0);
      tick();
      idle(0);
      #3;
      chk($sformatf("vec%0d.flush", i), flush, vecs[i].fl);
      chk($sformatf("vec%0d.we2", i), pc_we, 1);
      tick();
    end

    // FLUSH ignores a jr presented during the bubble.
    drv(1, 5'd1, 5'd0, 0, 0, 0, 0);
    #3;
    ck7("fl_j", 1, 2, 0, 0, 0, 0, 0);
    tick();
    drv(1, 5'd4, 5'd0, 0, 0, 0, 1);
    #3;
    ck7("fl_bub", 1, 0, 1, 0, 0, 0, 0);
    tick();
    idle(0);
    #3;
    ck7("fl_after", 1, 0, 0, 0, 0, 0, 0);
    tick();

    // mul with md_rdy in the 5th MD_WAIT cycle.
    drv(1, 5'd0, 5'd6, 0, 0, 0, 0);
    #3;
    ck7("mul_dec", 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle(0);
    #3;
    ck7("mul_iss", 0, 0, 0, 1, 0, 1, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #3;
      ck7($sformatf("mul_w%0d", k), 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    md_rdy = 1;
    #3;
    ck7("mul_done", 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle(0);
    #3;
    ck7("mul_run", 1, 0, 0, 0, 0, 0, 0);
    tick();

    // div with md_rdy held high throughout.
    drv(1, 5'd0, 5'd7, 0, 0, 0, 1);
    #3;
    ck7("div_dec", 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle(1);
    #3;
    ck7("div_iss", 0, 0, 0, 0, 1, 1, 0);
    tick();
    #3;
    ck7("div_done", 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle(0);
    #3;
    ck7("div_run", 1, 0, 0, 0, 0, 0, 0);
    tick();

    // Long wait without md_rdy.
    drv(1, 5'd0, 5'd6, 0, 0, 0, 0);
    tick();
    idle(0);
    tick();
`ifdef PC_SEQ_TIMEOUT_EN
    for (int k = 0; k < TO - 1; k++) begin
      #3;
      ck7($sformatf("to_w%0d", k), 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    #3;
    ck7("to_hit", 1, 0, 0, 0, 0, 0, 1);
    tick();
    #3;
    ck7("to_run", 1, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 5'd0, 5'd7, 0, 0, 0, 0);
    tick();
    idle(0);
    tick();
    for (int k = 0; k < TO - 1; k++) tick();
    md_rdy = 1;
    #3;
    ck7("to_rdy", 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle(0);
`else
    for (int k = 0; k < 10; k++) begin
      #3;
      ck7($sformatf("wait%0d", k), 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    md_rdy = 1;
    #3;
    ck7("wait_done", 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle(0);
`endif

    // Reset for 2 cycles in the middle of MD_WAIT.
    drv(1, 5'd0, 5'd6, 0, 0, 0, 0);
    tick();
    idle(0);
    tick();
    tick();
    reset = 0;
    md_rdy = 1;
    #3;
    ck7("rmw0", 0, 0, 0, 0, 0, 0, 0);
    tick();
    #3;
    ck7("rmw1", 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1;
    drv(1, 5'd5, 5'd0, 0, 0, 0, 0);
    #3;
    ck7("rmw_rel", 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle(0);
    #3;
    ck7("rmw_nopulse", 1, 0, 0, 0, 0, 0, 0);
    tick();

    // Random run against the model; DUT is in RUN here.
    m_bubble = 0;
    m_start = 0;
    m_waiting = 0;
    m_waited = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset = ($urandom_range(0, 39) != 0);
      inst_valid = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 8);
      opcode = (r == 8) ? 5'($urandom) : ops[r];
      r = $urandom_range(0, 3);
      alu_op = (r == 0) ? 5'd6 : (r == 1) ? 5'd7 : 5'($urandom);
      alu_ne = 1'($urandom);
      alu_lt = 1'($urandom);
      rstatus_nz = 1'($urandom);
      md_rdy = ($urandom_range(0, 9) < 3);
      #3;
      model_eval();
      ck7($sformatf("rnd%0d", c), e_we, e_sel, e_fl,
          e_mu, e_dv, e_st, e_to);
      tick();
      m_bubble = n_bubble;
      m_start = n_start;
      m_waiting = n_waiting;
      m_waited = n_waited;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
